// File: rtl/rr_arbiter_16_pkg.sv
// ---------------------------------------------------------------------------
// rr_arbiter_16_pkg
//  Shared definitions for the 16-way round-robin arbiter slice.
//  - state_t : arbiter FSM states (idle / grant held)
//  - N_REQ   : number of requesters
//  - IDX_W   : width of an encoded requester index
// ---------------------------------------------------------------------------
package rr_arbiter_16_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage : rr_arbiter_16_pkg

// File: rtl/decoder_4_to_16.sv
// ---------------------------------------------------------------------------
// decoder_4_to_16
//  Enabled binary-to-one-hot decoder.
//  Ports:
//   i_i  in  4   encoded index
//   en_i in  1   enable; when low the output is all zero
//   y_o  out 16  one-hot output, bit i_i set when enabled
// ---------------------------------------------------------------------------
module decoder_4_to_16
  import rr_arbiter_16_pkg::*;
(
  input  logic [IDX_W-1:0] i_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] y_o
);

  always_comb begin
    y_o = '0;
    if (en_i) begin
      y_o[i_i] = 1'b1;
    end
  end

endmodule : decoder_4_to_16

// File: rtl/rr_arbiter_16.sv
// ---------------------------------------------------------------------------
// rr_arbiter_16
//  Round-robin arbiter sharing one resource among 16 requesters, with a
//  hold-limit counter that force-releases a grant after MAX_HOLD cycles.
//  Parameters:
//   MAX_HOLD  max cycles a grant is held before forced release (2..255)
//   CNT_W     hold counter width, MAX_HOLD < 2**CNT_W
//  Ports:
//   clk_i      in   1   clock, rising edge
//   rst_n_i    in   1   asynchronous active-low reset
//   en_i       in   1   enable; low = no new grants, current grant dropped
//   req_i      in   16  request vector, bit n = requester n
//   rel_i      in   1   current holder releases the resource
//   gnt_o      out  16  one-hot grant, zero when no grant is active
//   gnt_idx_o  out  4   encoded index of the current (or last) holder
//   gnt_vld_o  out  1   a grant is active
//   timeout_o  out  1   one-cycle pulse after a forced release
// ---------------------------------------------------------------------------
module rr_arbiter_16
  import rr_arbiter_16_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic             rel_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_vld_o,
  output logic             timeout_o
);

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_vld;
  logic [CNT_W-1:0]   hold_cnt;
  logic               timeout;

  logic [IDX_W-1:0]   winner;
  logic               any_req;
  logic               holder_req;
  logic               hold_at_max;

  // Rotating priority search: walk downward over the offsets so that the
  // smallest offset from ptr with a set request is the last one written,
  // which makes it the winner. The 4-bit add wraps 15 -> 0 naturally.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand   = '0;
    winner = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr + IDX_W'(k);
      if (req_i[cand]) begin
        winner = cand;
      end
    end
  end

  assign any_req     = |req_i;
  assign holder_req  = req_i[gnt_idx];
  assign hold_at_max = (hold_cnt == CNT_W'(MAX_HOLD));

  // Arbiter FSM. Disable drops the grant without advancing the pointer so
  // the interrupted holder keeps its priority once the arbiter resumes.
  // A release that coincides with the hold limit is a normal release and
  // does not raise the timeout pulse.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      gnt_idx  <= '0;
      gnt_vld  <= 1'b0;
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en_i && any_req) begin
            state    <= ST_GRANT;
            gnt_idx  <= winner;
            gnt_vld  <= 1'b1;
            hold_cnt <= CNT_W'(1);
          end
        end
        ST_GRANT: begin
          if (!en_i) begin
            state    <= ST_IDLE;
            gnt_vld  <= 1'b0;
            hold_cnt <= '0;
          end else if (rel_i || !holder_req || hold_at_max) begin
            state    <= ST_IDLE;
            gnt_vld  <= 1'b0;
            hold_cnt <= '0;
            ptr      <= gnt_idx + IDX_W'(1);
            timeout  <= hold_at_max && !rel_i && holder_req;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt_idx_o = gnt_idx;
  assign gnt_vld_o = gnt_vld;
  assign timeout_o = timeout;

  decoder_4_to_16 u_gnt_dec (
    .i_i  (gnt_idx),
    .en_i (gnt_vld),
    .y_o  (gnt_o)
  );

endmodule : rr_arbiter_16
